// File: rtl/midi_pkg.sv
// Shared MIDI constants and enums for the note-tracker path.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [7:0] REALTIME_MIN     = 8'hF8;
  localparam logic [7:0] SYS_MIN          = 8'hF0;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} parse_state_t;
  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_REMOVE, OP_CLEAR} stack_op_t;

endpackage

// File: rtl/note_stack.sv
// Last-note-priority stack of held keys; entry 0 is the most recent key.
// Top-of-stack outputs are registered from next-state so they move with the stack.
module note_stack
  import midi_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_op,
  input  logic [6:0] i_key,
  input  logic [6:0] i_vel,
  output logic [6:0] o_top_key,
  output logic [6:0] o_top_vel,
  output logic       o_empty,
  output logic       o_overflow,
  output logic       o_changed
);

  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [6:0]    r_key [STACK_DEPTH];
  logic [6:0]    r_vel [STACK_DEPTH];
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_top_key;
  logic [6:0]    r_top_vel;
  logic          r_empty;
  logic          r_overflow;
  logic          r_changed;

  logic [6:0]    w_key_nxt [STACK_DEPTH];
  logic [6:0]    w_vel_nxt [STACK_DEPTH];
  logic [CW-1:0] w_cnt_nxt;
  logic          w_hit;
  int            w_hit_idx;
  logic          w_evict;
  logic          w_empty_nxt;
  logic [6:0]    w_top_key;
  logic [6:0]    w_top_vel;

  // Keys are unique in the stack, so the first valid match is the only one.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = STACK_DEPTH - 1;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!w_hit && (i < int'(r_cnt)) && (r_key[i] == i_key)) begin
        w_hit     = 1'b1;
        w_hit_idx = i;
      end
    end
  end

  always_comb begin
    w_key_nxt = r_key;
    w_vel_nxt = r_vel;
    w_cnt_nxt = r_cnt;
    w_evict   = 1'b0;
    case (i_op)
      OP_PUSH: begin
        // Without a hit the whole stack shifts, dropping the bottom entry when full.
        for (int i = 1; i < STACK_DEPTH; i++) begin
          if (i <= w_hit_idx) begin
            w_key_nxt[i] = r_key[i-1];
            w_vel_nxt[i] = r_vel[i-1];
          end
        end
        w_key_nxt[0] = i_key;
        w_vel_nxt[0] = i_vel;
        if (!w_hit) begin
          if (r_cnt == CW'(STACK_DEPTH)) w_evict = 1'b1;
          else                            w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      OP_REMOVE: begin
        if (w_hit) begin
          for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            if (i >= w_hit_idx) begin
              w_key_nxt[i] = r_key[i+1];
              w_vel_nxt[i] = r_vel[i+1];
            end
          end
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      OP_CLEAR: w_cnt_nxt = '0;
      default: ;
    endcase
    w_empty_nxt = (w_cnt_nxt == '0);
    w_top_key   = w_empty_nxt ? 7'd0 : w_key_nxt[0];
    w_top_vel   = w_empty_nxt ? 7'd0 : w_vel_nxt[0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_key[i] <= '0;
        r_vel[i] <= '0;
      end
      r_cnt      <= '0;
      r_top_key  <= '0;
      r_top_vel  <= '0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_changed  <= 1'b0;
    end else begin
      r_key     <= w_key_nxt;
      r_vel     <= w_vel_nxt;
      r_cnt     <= w_cnt_nxt;
      r_top_key <= w_top_key;
      r_top_vel <= w_top_vel;
      r_empty   <= w_empty_nxt;
      r_changed <= (w_top_key != r_top_key) || (w_top_vel != r_top_vel) ||
                   (w_empty_nxt != r_empty);
      if (w_evict) r_overflow <= 1'b1;
    end
  end

  assign o_top_key  = r_top_key;
  assign o_top_vel  = r_top_vel;
  assign o_empty    = r_empty;
  assign o_overflow = r_overflow;
  assign o_changed  = r_changed;

endmodule

// File: rtl/midi_note_tracker.sv
// MIDI byte-stream parser feeding a last-note-priority stack; drives NOTE/VELOCITY/GATE.
// state   | meaning
// IDLE    | no running status, data bytes discarded
// WAIT_D1 | status known, waiting for first data byte
// WAIT_D2 | first data byte stored, waiting for second
module midi_note_tracker
  import midi_pkg::*;
#(
  parameter int         STACK_DEPTH    = 8,
  parameter bit         CHAN_FILTER_EN = 1'b0,
  parameter logic [3:0] CHANNEL        = 4'd0
) (
  input  logic       CLK_I,
  input  logic       RESET_N,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_ERR,
  output logic [7:0] NOTE,
  output logic [6:0] VELOCITY,
  output logic       GATE,
  output logic       NOTE_STRB,
  output logic       OVERFLOW
);

  parse_state_t r_state;
  logic [7:0]   r_status;
  logic [6:0]   r_d1;
  stack_op_t    r_op;
  logic [6:0]   r_key;
  logic [6:0]   r_vel;

  stack_op_t    w_op;
  logic [3:0]   w_hi;
  logic         w_chan_ok;
  logic [6:0]   w_top_key;
  logic [6:0]   w_top_vel;
  logic         w_empty;
  logic         w_overflow;
  logic         w_changed;

  assign w_hi      = r_status[7:4];
  assign w_chan_ok = (CHAN_FILTER_EN == 1'b0) || (r_status[3:0] == CHANNEL);

  // Operation implied if the current byte completes a two-byte message.
  always_comb begin
    w_op = OP_NONE;
    if (w_chan_ok) begin
      case (w_hi)
        NOTE_ON:  w_op = (RX_DATA[6:0] != 7'd0) ? OP_PUSH : OP_REMOVE;
        NOTE_OFF: w_op = OP_REMOVE;
        CTRL:     if (r_d1 == CC_ALL_NOTES_OFF) w_op = OP_CLEAR;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_status <= '0;
      r_d1     <= '0;
      r_op     <= OP_NONE;
      r_key    <= '0;
      r_vel    <= '0;
    end else begin
      r_op <= OP_NONE;
      if (RX_VALID) begin
        if (RX_ERR) begin
          r_state  <= IDLE;
          r_status <= '0;
        end else if (RX_DATA >= REALTIME_MIN) begin
        end else if (RX_DATA >= SYS_MIN) begin
          r_state  <= IDLE;
          r_status <= '0;
        end else if (RX_DATA[7]) begin
          r_status <= RX_DATA;
          r_state  <= WAIT_D1;
        end else begin
          case (r_state)
            WAIT_D1: begin
              r_d1 <= RX_DATA[6:0];
              // Program change and channel pressure complete here and carry no op.
              if ((w_hi != PROG) && (w_hi != CHPRESS)) r_state <= WAIT_D2;
            end
            WAIT_D2: begin
              r_state <= WAIT_D1;
              r_op    <= w_op;
              r_key   <= r_d1;
              r_vel   <= RX_DATA[6:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  note_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_note_stack (
    .i_clk      (CLK_I),
    .i_rst_n    (RESET_N),
    .i_op       (r_op),
    .i_key      (r_key),
    .i_vel      (r_vel),
    .o_top_key  (w_top_key),
    .o_top_vel  (w_top_vel),
    .o_empty    (w_empty),
    .o_overflow (w_overflow),
    .o_changed  (w_changed)
  );

  assign NOTE      = {1'b0, w_top_key};
  assign VELOCITY  = w_top_vel;
  assign GATE      = ~w_empty;
  assign NOTE_STRB = w_changed;
  assign OVERFLOW  = w_overflow;

endmodule

// File: tb/tb_midi_note_tracker.sv
// Bench for midi_note_tracker: an omni instance and a channel-2-filtered instance
// share one byte stream and are compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_midi_note_tracker;

  localparam int DEPTH = 8;

  logic       CLK_I = 1'b0;
  logic       RESET_N;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ERR;

  logic [7:0] note0, note1;
  logic [6:0] vel0, vel1;
  logic       gate0, gate1, strb0, strb1, ovf0, ovf1;
  logic [16:0] act0, act1;

  always #5 CLK_I = ~CLK_I;

  midi_note_tracker #(.STACK_DEPTH(DEPTH), .CHAN_FILTER_EN(1'b0), .CHANNEL(4'd0)) dut_omni (
    .CLK_I(CLK_I), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR),
    .NOTE(note0), .VELOCITY(vel0), .GATE(gate0), .NOTE_STRB(strb0), .OVERFLOW(ovf0));

  midi_note_tracker #(.STACK_DEPTH(DEPTH), .CHAN_FILTER_EN(1'b1), .CHANNEL(4'd2)) dut_ch2 (
    .CLK_I(CLK_I), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR),
    .NOTE(note1), .VELOCITY(vel1), .GATE(gate1), .NOTE_STRB(strb1), .OVERFLOW(ovf1));

  assign act0 = {note0, vel0, gate0, ovf0};
  assign act1 = {note1, vel1, gate1, ovf1};

  int checks = 0;
  int errors = 0;
  int strb_cnt0 = 0;
  int strb_cnt1 = 0;

  always @(posedge CLK_I) begin
    #1;
    if (strb0 === 1'b1) strb_cnt0++;
    if (strb1 === 1'b1) strb_cnt1++;
  end

  // Reference model: message assembly from running status, stacks as queues of {key,vel}.
  int          m_status;
  int          m_got;
  logic [6:0]  m_d1;
  logic [13:0] m_stk [2][$];
  bit          m_ovf [2];
  logic [15:0] m_last [2];
  int          m_chg [2];

  function automatic logic [16:0] exp_tuple(input int k);
    logic [13:0] t;
    if (m_stk[k].size() == 0) return {8'h00, 7'h00, 1'b0, m_ovf[k]};
    t = m_stk[k][0];
    return {1'b0, t[13:7], t[6:0], 1'b1, m_ovf[k]};
  endfunction

  function automatic int m_find(input int k, input logic [6:0] key);
    logic [13:0] t;
    for (int j = 0; j < m_stk[k].size(); j++) begin
      t = m_stk[k][j];
      if (t[13:7] == key) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_status = -1;
    m_got    = 0;
    for (int k = 0; k < 2; k++) begin
      m_stk[k].delete();
      m_ovf[k]  = 1'b0;
      m_last[k] = '0;
    end
  endtask

  task automatic model_exec(input int st, input logic [6:0] d1, input logic [6:0] d2);
    int hi;
    int ch;
    int pos;
    logic [16:0] t;
    hi = st / 16;
    ch = st % 16;
    for (int k = 0; k < 2; k++) begin
      if (k == 0 || ch == 2) begin
        pos = m_find(k, d1);
        if (hi == 9 && d2 != 0) begin
          if (pos >= 0) m_stk[k].delete(pos);
          else if (m_stk[k].size() == DEPTH) begin
            void'(m_stk[k].pop_back());
            m_ovf[k] = 1'b1;
          end
          m_stk[k].push_front({d1, d2});
        end else if (hi == 8 || hi == 9) begin
          if (pos >= 0) m_stk[k].delete(pos);
        end else if (hi == 11 && d1 == 7'd123) begin
          m_stk[k].delete();
        end
      end
      t = exp_tuple(k);
      if (t[16:1] != m_last[k]) begin
        m_chg[k]++;
        m_last[k] = t[16:1];
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic e);
    int need;
    if (e) m_status = -1;
    else if (b >= 8'hF8) begin
    end else if (b >= 8'hF0) m_status = -1;
    else if (b[7]) begin
      m_status = int'(b);
      m_got    = 0;
    end else if (m_status >= 0) begin
      need = (m_status / 16 == 12 || m_status / 16 == 13) ? 1 : 2;
      if (m_got == 0) m_d1 = b[6:0];
      m_got++;
      if (m_got == need) begin
        m_got = 0;
        if (need == 2) model_exec(m_status, m_d1, b[6:0]);
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK_I);
    RX_VALID = 1'b1; RX_DATA = b; RX_ERR = 1'b0;
    model_byte(b, 1'b0);
  endtask

  task automatic send_err(input logic [7:0] b);
    @(negedge CLK_I);
    RX_VALID = 1'b1; RX_DATA = b; RX_ERR = 1'b1;
    model_byte(b, 1'b1);
  endtask

  task automatic idle(input int n);
    @(negedge CLK_I);
    RX_VALID = 1'b0; RX_ERR = 1'b0;
    repeat (n) @(negedge CLK_I);
  endtask

  task automatic do_reset();
    @(negedge CLK_I);
    RX_VALID = 1'b0; RX_ERR = 1'b0; RESET_N = 1'b0;
    model_reset();
    @(negedge CLK_I);
    RESET_N = 1'b1;
    @(negedge CLK_I);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; RX_VALID = 1'b0; RX_ERR = 1'b0; RX_DATA = 8'h00;
    model_reset();
    repeat (2) @(negedge CLK_I);
    checks++;
    if (act0 !== 17'h0 || act1 !== 17'h0) begin
      errors++; $display("FAIL reset_outputs: got %h/%h want 0", act0, act1);
    end
    checks++;
    if (strb0 !== 1'b0 || strb1 !== 1'b0) begin
      errors++; $display("FAIL reset_strobe: got %b/%b want 0", strb0, strb1);
    end
    RESET_N = 1'b1;
    @(negedge CLK_I);
  endtask

  task automatic test_latency();
    int s0;
    do_reset();
    s0 = strb_cnt0;
    send(8'h90); send(8'h3C); send(8'h64);
    idle(0);
    checks++;
    if (act0 !== 17'h0) begin
      errors++; $display("FAIL latency_early: got %h want 0", act0);
    end
    @(negedge CLK_I);
    checks++;
    if (act0 !== {8'h3C, 7'd100, 1'b1, 1'b0} || strb0 !== 1'b1) begin
      errors++; $display("FAIL latency_update: got %h strb %b want %h strb 1", act0, strb0, {8'h3C, 7'd100, 1'b1, 1'b0});
    end
    @(negedge CLK_I);
    checks++;
    if (strb0 !== 1'b0 || strb_cnt0 - s0 != 1) begin
      errors++; $display("FAIL latency_single_strobe: strb %b count %0d want 0 and 1", strb0, strb_cnt0 - s0);
    end
  endtask

  task automatic test_running_status();
    logic [7:0] seq [10];
    logic [16:0] e;
    int c0, c1, s0, s1;
    seq = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h80, 8'h40, 8'h00, 8'h3C, 8'h00};
    do_reset();
    c0 = m_chg[0]; c1 = m_chg[1]; s0 = strb_cnt0; s1 = strb_cnt1;
    for (int i = 0; i < 10; i++) begin
      send(seq[i]);
      if (i == 2 || i == 4 || i == 7 || i == 9) begin
        idle(3);
        for (int k = 0; k < 2; k++) begin
          e = exp_tuple(k);
          checks++;
          if (((k == 0) ? act0 : act1) !== e) begin
            errors++; $display("FAIL running_status[%0d] dut%0d: got %h want %h", i, k, (k == 0) ? act0 : act1, e);
          end
        end
      end
      if (i == 4) begin
        checks++;
        if (note0 !== 8'h40 || vel0 !== 7'h50) begin
          errors++; $display("FAIL running_status_note: got %h/%h want 40/50", note0, vel0);
        end
      end
    end
    checks++;
    if (strb_cnt0 - s0 != m_chg[0] - c0 || strb_cnt1 - s1 != m_chg[1] - c1) begin
      errors++; $display("FAIL running_status_strobes: got %0d/%0d want %0d/%0d", strb_cnt0 - s0, strb_cnt1 - s1, m_chg[0] - c0, m_chg[1] - c1);
    end
  endtask

  task automatic test_realtime();
    do_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    idle(3);
    checks++;
    if (act0 !== {8'h3C, 7'd100, 1'b1, 1'b0} || act0 !== exp_tuple(0)) begin
      errors++; $display("FAIL realtime_mid_msg: got %h want %h", act0, exp_tuple(0));
    end
    send(8'h90); send(8'h3D); send(8'hF0); send(8'h64);
    idle(3);
    checks++;
    if (act0 !== {8'h3C, 7'd100, 1'b1, 1'b0} || act1 !== exp_tuple(1)) begin
      errors++; $display("FAIL sysex_abort: got %h/%h want %h/%h", act0, act1, exp_tuple(0), exp_tuple(1));
    end
  endtask

  task automatic test_overflow();
    int s0, s1;
    do_reset();
    send(8'h92);
    for (int i = 0; i < 9; i++) begin
      send(8'h40 + 8'(i));
      send(8'h10 + 8'(i));
    end
    idle(3);
    checks++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || act0 !== exp_tuple(0) || act1 !== exp_tuple(1)) begin
      errors++; $display("FAIL overflow_set: got %h/%h want %h/%h", act0, act1, exp_tuple(0), exp_tuple(1));
    end
    s0 = strb_cnt0; s1 = strb_cnt1;
    send(8'h82); send(8'h40); send(8'h00);
    idle(4);
    checks++;
    if (strb_cnt0 != s0 || strb_cnt1 != s1 || note0 !== 8'h48) begin
      errors++; $display("FAIL evicted_release: strobes %0d/%0d note %h want 0/0 note 48", strb_cnt0 - s0, strb_cnt1 - s1, note0);
    end
    send(8'h48); send(8'h00);
    idle(3);
    checks++;
    if (act0 !== exp_tuple(0) || note0 !== 8'h47 || ovf0 !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky_release: got %h want %h", act0, exp_tuple(0));
    end
  endtask

  task automatic test_all_notes_off();
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50); send(8'h40); send(8'h30);
    idle(3);
    checks++;
    if (act0 !== {8'h40, 7'h30, 1'b1, 1'b0}) begin
      errors++; $display("FAIL three_held: got %h want %h", act0, {8'h40, 7'h30, 1'b1, 1'b0});
    end
    send(8'hB0); send(8'h7B); send(8'h00);
    idle(0);
    @(negedge CLK_I);
    checks++;
    if (gate0 !== 1'b0 || act0 !== exp_tuple(0)) begin
      errors++; $display("FAIL all_notes_off: got %h want %h", act0, exp_tuple(0));
    end
  endtask

  task automatic test_rx_err();
    do_reset();
    send(8'h92); send(8'h3C); send_err(8'h64); send(8'h64); send(8'h3D); send(8'h40);
    idle(3);
    checks++;
    if (act0 !== 17'h0 || act1 !== 17'h0 || act0 !== exp_tuple(0)) begin
      errors++; $display("FAIL rx_err_abort: got %h/%h want 0", act0, act1);
    end
    send(8'h92); send(8'h3C); send(8'h64);
    idle(3);
    checks++;
    if (act0 !== exp_tuple(0) || act1 !== {8'h3C, 7'd100, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rx_err_recover: got %h/%h want %h/%h", act0, act1, exp_tuple(0), exp_tuple(1));
    end
  endtask

  task automatic test_filter();
    int s1;
    do_reset();
    send(8'h91); send(8'h3C); send(8'h64);
    idle(3);
    checks++;
    if (act1 !== 17'h0 || act0 !== {8'h3C, 7'd100, 1'b1, 1'b0}) begin
      errors++; $display("FAIL filter_reject: got %h/%h want %h/0", act0, act1, {8'h3C, 7'd100, 1'b1, 1'b0});
    end
    s1 = strb_cnt0;
    send(8'h92); send(8'h3C); send(8'h64);
    idle(3);
    checks++;
    if (note1 !== 8'h3C || act1 !== exp_tuple(1) || strb_cnt0 != s1) begin
      errors++; $display("FAIL filter_accept: got %h omni_strb %0d want %h omni_strb 0", act1, strb_cnt0 - s1, exp_tuple(1));
    end
  endtask

  task automatic test_reset_mid_message();
    int s0;
    do_reset();
    send(8'h92); send(8'h40); send(8'h64);
    send(8'h92); send(8'h3C);
    idle(0);
    #2 RESET_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act0 !== 17'h0 || act1 !== 17'h0) begin
      errors++; $display("FAIL async_reset: got %h/%h want 0", act0, act1);
    end
    @(negedge CLK_I);
    RESET_N = 1'b1;
    s0 = strb_cnt0 + strb_cnt1;
    send(8'h64);
    idle(4);
    checks++;
    if (act0 !== 17'h0 || act1 !== 17'h0 || strb_cnt0 + strb_cnt1 != s0) begin
      errors++; $display("FAIL partial_lost: got %h/%h strobes %0d want 0", act0, act1, strb_cnt0 + strb_cnt1 - s0);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1, s0, s1, r;
    logic [7:0] st;
    logic [6:0] k, v;
    logic [16:0] e;
    do_reset();
    c0 = m_chg[0]; c1 = m_chg[1]; s0 = strb_cnt0; s1 = strb_cnt1;
    for (int m = 0; m < 400; m++) begin
      r  = int'($urandom_range(0, 99));
      k  = 7'h30 + 7'($urandom_range(0, 11));
      v  = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      st = {4'h9, 4'($urandom_range(0, 3))};
      if (r < 45)      st[7:4] = 4'h9;
      else if (r < 70) st[7:4] = 4'h8;
      else if (r < 76) begin
        st[7:4] = 4'hB;
        k = ($urandom_range(0, 1) == 1) ? 7'd123 : 7'd7;
      end
      else if (r < 82) st[7:4] = 4'hC;
      else if (r < 86) st[7:4] = 4'hD;
      else if (r < 90) st[7:4] = 4'hE;
      else             st[7:4] = 4'hA;
      if (r >= 93 && r < 96) send(8'hF0 + 8'($urandom_range(0, 7)));
      else if (r >= 96) send_err(8'($urandom_range(0, 255)));
      else begin
        if ($urandom_range(0, 2) != 0) send(st);
        if ($urandom_range(0, 9) == 0) send(8'hF8 + 8'($urandom_range(0, 7)));
        send({1'b0, k});
        if (st[7:4] != 4'hC && st[7:4] != 4'hD) send({1'b0, v});
      end
      if (m % 40 == 39) begin
        idle(3);
        for (int d = 0; d < 2; d++) begin
          e = exp_tuple(d);
          checks++;
          if (((d == 0) ? act0 : act1) !== e) begin
            errors++; $display("FAIL random[%0d] dut%0d: got %h want %h", m, d, (d == 0) ? act0 : act1, e);
          end
        end
      end
    end
    idle(3);
    checks++;
    if (strb_cnt0 - s0 != m_chg[0] - c0 || strb_cnt1 - s1 != m_chg[1] - c1) begin
      errors++; $display("FAIL random_strobes: got %0d/%0d want %0d/%0d", strb_cnt0 - s0, strb_cnt1 - s1, m_chg[0] - c0, m_chg[1] - c1);
    end
  endtask

  initial begin
    m_chg[0] = 0; m_chg[1] = 0;
    test_reset();
    test_latency();
    test_running_status();
    test_realtime();
    test_overflow();
    test_all_notes_off();
    test_rx_err();
    test_filter();
    test_reset_mid_message();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
